// File: rtl/board_input_unit.sv
// Board input peripheral: synchronises switches and buttons, debounces the buttons and
// latches press events behind a small CPU register window with a maskable interrupt.
module board_input_unit #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] switches,
  input  logic        btn_u,
  input  logic        btn_d,
  input  logic        btn_l,
  input  logic        btn_r,
  input  logic [1:0]  addr,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        irq
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]             btn_raw;
  logic [15:0]            sw_meta_q, sw_sync_q;
  logic [3:0]             btn_meta_q, btn_sync_q;
  logic [3:0]             st_q, st_d;
  logic [3:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]             flags_q, flags_d;
  logic [3:0]             mask_q, mask_d;
  logic [3:0]             new_press;
  logic [31:0]            rd_data_d;
  logic                   irq_d;

  // Bit order: [0]=up, [1]=down, [2]=left, [3]=right.
  assign btn_raw = {btn_r, btn_l, btn_d, btn_u};

  always_comb begin
    st_d  = st_q;
    cnt_d = '0;
    for (int i = 0; i < 4; i++) begin
      if (btn_sync_q[i] != st_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          st_d[i] = btn_sync_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign new_press = st_d & ~st_q;

  always_comb begin
    flags_d   = flags_q | new_press;
    mask_d    = mask_q;
    rd_data_d = rd_data;
    if (rd_en) begin
      unique case (addr)
        2'd0: rd_data_d = {16'h0, sw_sync_q};
        2'd1: rd_data_d = {28'h0, st_q};
        2'd2: rd_data_d = {28'h0, flags_q};
        2'd3: rd_data_d = {28'h0, mask_q};
        default: rd_data_d = '0;
      endcase
      // Clear-on-read keeps a press accepted on the same edge.
      if (addr == 2'd2) flags_d = new_press;
    end
    if (wr_en && addr == 2'd3) mask_d = wr_data[3:0];
    // Old mask is used here, so a mask write reaches irq one edge later.
    irq_d = |(flags_d & mask_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      btn_meta_q <= '0;
      btn_sync_q <= '0;
      st_q       <= '0;
      cnt_q      <= '0;
      flags_q    <= '0;
      mask_q     <= 4'hF;
      rd_data    <= '0;
      irq        <= 1'b0;
    end else begin
      sw_meta_q  <= switches;
      sw_sync_q  <= sw_meta_q;
      btn_meta_q <= btn_raw;
      btn_sync_q <= btn_meta_q;
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      flags_q    <= flags_d;
      mask_q     <= mask_d;
      rd_data    <= rd_data_d;
      irq        <= irq_d;
    end
  end

endmodule

// File: tb/tb_board_input_unit.sv
// Directed bench for board_input_unit with hand-computed expectations.
module tb_board_input_unit;

  logic        clk;
  logic        reset;
  logic [15:0] switches;
  logic        btn_u, btn_d, btn_l, btn_r;
  logic [1:0]  addr;
  logic        rd_en, wr_en;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        irq;

  int n_checks;
  int n_errors;
  logic [31:0] d;

  board_input_unit #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .switches(switches),
    .btn_u(btn_u),
    .btn_d(btn_d),
    .btn_l(btn_l),
    .btn_r(btn_r),
    .addr(addr),
    .rd_en(rd_en),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .rd_data(rd_data),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_read(input logic [1:0] a, output logic [31:0] data);
    addr  = a;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    data  = rd_data;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] data);
    addr    = a;
    wr_data = data;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    switches = '0;
    {btn_u, btn_d, btn_l, btn_r} = '0;
    addr = '0; rd_en = 1'b0; wr_en = 1'b0; wr_data = '0;

    // 1. Reset state
    ticks(2);
    reset = 1'b0;
    check_eq("reset_irq", {31'h0, irq}, 32'h0);
    check_eq("reset_rd_data", rd_data, 32'h0);
    do_read(2'd0, d); check_eq("reset_addr0", d, 32'h0);
    do_read(2'd1, d); check_eq("reset_addr1", d, 32'h0);
    do_read(2'd2, d); check_eq("reset_addr2", d, 32'h0);
    do_read(2'd3, d); check_eq("reset_addr3", d, 32'h0000000F);

    // 2. Switch synchronisation; rd_data holds while rd_en is low
    switches = 16'h0003;
    ticks(3);
    do_read(2'd0, d); check_eq("switches_3", d, 32'h3);
    ticks(2);
    check_eq("rd_data_hold", rd_data, 32'h3);

    // 3. btn_u press: accepted on the 6th edge after the pin change
    btn_u = 1'b1;
    ticks(5);
    check_eq("u_irq_before", {31'h0, irq}, 32'h0);
    do_read(2'd1, d); check_eq("u_level_edge6_old", d, 32'h0);
    do_read(2'd1, d); check_eq("u_level_after", d, 32'h1);
    check_eq("u_irq_set", {31'h0, irq}, 32'h1);
    do_read(2'd2, d); check_eq("u_flags_read", d, 32'h1);
    check_eq("u_irq_cleared", {31'h0, irq}, 32'h0);
    do_read(2'd2, d); check_eq("u_flags_reread", d, 32'h0);

    // Release sets nothing
    btn_u = 1'b0;
    ticks(8);
    do_read(2'd1, d); check_eq("u_released_level", d, 32'h0);
    do_read(2'd2, d); check_eq("u_release_no_flag", d, 32'h0);

    // 4. Two-cycle glitch on btn_d is rejected
    btn_d = 1'b1;
    ticks(2);
    btn_d = 1'b0;
    ticks(8);
    do_read(2'd1, d); check_eq("d_glitch_level", d, 32'h0);
    check_eq("d_glitch_irq", {31'h0, irq}, 32'h0);
    do_read(2'd2, d); check_eq("d_glitch_flags", d, 32'h0);

    // 5. Masked press on btn_l, then unmask
    do_write(2'd3, 32'h0);
    btn_l = 1'b1;
    ticks(8);
    btn_l = 1'b0;
    do_read(2'd3, d); check_eq("mask_zero", d, 32'h0);
    check_eq("l_masked_irq", {31'h0, irq}, 32'h0);
    do_write(2'd3, 32'h4);
    check_eq("l_irq_write_edge", {31'h0, irq}, 32'h0);
    tick();
    check_eq("l_irq_after_mask", {31'h0, irq}, 32'h1);

    // 6. btn_r accepted on the same edge as the clearing read of flags
    btn_r = 1'b1;
    ticks(5);
    do_read(2'd2, d); check_eq("r_clear_old_flags", d, 32'h4);
    check_eq("r_irq_masked", {31'h0, irq}, 32'h0);
    do_read(2'd2, d); check_eq("r_flag_kept", d, 32'h8);
    do_read(2'd1, d); check_eq("r_level", d, 32'h8);
    btn_r = 1'b0;
    ticks(8);

    // Reset in the middle of a btn_u debounce
    btn_u = 1'b1;
    ticks(3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("rst_mid_irq", {31'h0, irq}, 32'h0);
    do_read(2'd1, d); check_eq("rst_mid_levels", d, 32'h0);
    do_read(2'd2, d); check_eq("rst_mid_flags", d, 32'h0);
    do_read(2'd3, d); check_eq("rst_mid_mask", d, 32'hF);
    ticks(2);
    do_read(2'd1, d); check_eq("rst_reaccept_old", d, 32'h0);
    do_read(2'd1, d); check_eq("rst_reaccept_new", d, 32'h1);
    check_eq("rst_reaccept_irq", {31'h0, irq}, 32'h1);

    // Simultaneous read and write of the mask returns the old value
    addr = 2'd3; wr_data = 32'h2; rd_en = 1'b1; wr_en = 1'b1;
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
    check_eq("rdwr_old_mask", rd_data, 32'hF);
    do_write(2'd1, 32'hF);
    do_read(2'd3, d); check_eq("mask_after_rdwr", d, 32'h2);
    check_eq("irq_u_masked", {31'h0, irq}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
